count_sequencer: RTL

//  Run controller for the 4-bit wrapping down-counter datapath (sequence HI..LO, then back to HI).

---
 rtl/count_sequencer_pkg.sv | 13 +
 rtl/count_sequencer_if.sv | 22 ++
 rtl/count_sequencer_step_counter.sv | 20 ++
 rtl/count_sequencer.sv | 88 ++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: shared widths, counter range and FSM state encoding for count_sequencer
package count_sequencer_pkg;
   localparam int CS_W      = 4;
   localparam int CS_LO     = 5;
   localparam int CS_HI     = 14;
   localparam int CS_STEP_W = 8;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_FIN  = 2'd3
   } state_e;
endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: control-panel and counter-datapath signals of count_sequencer
//   master drives start/stop/hold/init/steps/val; slave (the sequencer) drives ce/load/load_val/busy/done/err/wraps
interface count_sequencer_if;
   import count_sequencer_pkg::*;
   logic                 start;
   logic                 stop;
   logic                 hold;
   logic [CS_W-1:0]      init;
   logic [CS_STEP_W-1:0] steps;
   logic [CS_W-1:0]      val;
   logic                 ce;
   logic                 load;
   logic [CS_W-1:0]      load_val;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [3:0]           wraps;
   modport master (output start, stop, hold, init, steps, val,
                   input  ce, load, load_val, busy, done, err, wraps);
   modport slave  (input  start, stop, hold, init, steps, val,
                   output ce, load, load_val, busy, done, err, wraps);
endinterface

// File: rtl/count_sequencer_step_counter.sv
// step_counter: loadable down-counter of remaining steps with enable and a last (==1) flag
//   clk, rst (async, active-high); load/d: load value; en: decrement; last: count equals 1
module step_counter #(
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   input  logic [STEP_W-1:0] d,
   output logic              last
);
   logic [STEP_W-1:0] cnt_q, cnt_d;
   // the zero guard keeps the count from underflowing
   always_comb cnt_d = load ? d : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   assign last = cnt_q == STEP_W'(1);
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: run controller loading a wrapping down-counter and issuing CE for STEPS cycles
//   clk, rst (async, active-high); bus (slave): start/stop/hold/init/steps/val in,
//   ce/load/load_val/busy/done/err/wraps out
module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter int W      = CS_W,
   parameter int LO     = CS_LO,
   parameter int HI     = CS_HI,
   parameter int STEP_W = CS_STEP_W
) (
   input  logic             clk,
   input  logic             rst,
   count_sequencer_if.slave bus
);
   localparam logic [W-1:0] LO_V = W'(LO);
   localparam logic [W-1:0] HI_V = W'(HI);
   state_e       state_q, state_d;
   logic [W-1:0] load_val_q, load_val_d;
   logic [3:0]   wraps_q, wraps_d;
   logic         done_q, done_d, err_q, err_d;
   logic         cnt_load, last, ce;
   // CE is combinational so HOLD/STOP take effect in the same cycle
   assign ce = state_q == S_RUN && !bus.hold && !bus.stop;
   step_counter #(.STEP_W(STEP_W)) u_steps (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .en   (ce),
      .d    (bus.steps),
      .last (last)
   );
   always_comb begin
      state_d    = state_q;
      load_val_d = load_val_q;
      wraps_d    = wraps_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cnt_load   = 1'b0;
      case (state_q)
         S_IDLE:
            if (bus.start && !bus.stop) begin
               if (bus.init < LO_V || bus.init > HI_V) err_d = 1'b1;
               else if (bus.steps == '0) begin
                  done_d  = 1'b1;
                  wraps_d = '0;
               end else begin
                  load_val_d = bus.init;
                  wraps_d    = '0;
                  cnt_load   = 1'b1;
                  state_d    = S_LOAD;
               end
            end
         S_LOAD: state_d = bus.stop ? S_IDLE : S_RUN;
         S_RUN:
            if (bus.stop) state_d = S_IDLE;
            else if (ce) begin
               if (bus.val == LO_V && wraps_q != 4'hF) wraps_d = wraps_q + 4'd1;
               if (last) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end
            end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= S_IDLE;
         load_val_q <= '0;
         wraps_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_val_q <= load_val_d;
         wraps_q    <= wraps_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   assign bus.ce       = ce;
   assign bus.load     = state_q == S_LOAD;
   assign bus.busy     = state_q == S_LOAD || state_q == S_RUN;
   assign bus.load_val = load_val_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.wraps    = wraps_q;
endmodule
